decode_alu_dmem: RTL and testbench



---
 rtl/decode_alu_dmem_pkg.sv | 25 ++
 rtl/decode_alu_dmem_alu.sv | 35 +++
 rtl/decode_alu_dmem_decoder.sv | 66 ++++++
 rtl/decode_alu_dmem_dmem.sv | 18 +
 rtl/decode_alu_dmem.sv | 45 ++++
 tb/tb_decode_alu_dmem.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/decode_alu_dmem_pkg.sv
// decode_alu_dmem_pkg: shared opcodes, functs, ALU commands and mux encodings
package decode_alu_dmem_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REG = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_AND, ALU_NAND, ALU_NOR, ALU_OR
  } aluCmd_t;
endpackage

// File: rtl/decode_alu_dmem_alu.sv
// alu32: 32-bit ALU with carry and signed overflow for add/sub/slt
module alu32
  import decode_alu_dmem_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  aluCmd_t     cmd,
  output logic [31:0] result,
  output logic        zero,
  output logic        carryout,
  output logic        overflow
);
  logic [32:0] sum, diff;
  logic addOvf, subOvf;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign addOvf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign subOvf = (a[31] != b[31]) && (diff[31] != a[31]);
  always_comb begin
    result = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (cmd)
      ALU_ADD: begin result = sum[31:0]; carryout = sum[32]; overflow = addOvf; end
      ALU_SUB: begin result = diff[31:0]; carryout = diff[32]; overflow = subOvf; end
      ALU_SLT: begin result = {31'b0, diff[31] ^ subOvf}; carryout = diff[32]; overflow = subOvf; end
      ALU_XOR: result = a ^ b;
      ALU_AND: result = a & b;
      ALU_NAND: result = ~(a & b);
      ALU_NOR: result = ~(a | b);
      ALU_OR: result = a | b;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/decode_alu_dmem_decoder.sv
// instruction_decoder: combinational control decode with reset gating of side effects
module instruction_decoder
  import decode_alu_dmem_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        aluZero,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [27:0] jImm,
  output logic [1:0]  pcSrc,
  output logic        regDst,
  output logic        regWrEn,
  output logic [1:0]  writebackSrc,
  output logic        memWrEn,
  output logic        aluSrcB,
  output logic        extSel,
  output aluCmd_t     aluCmd
);
  logic [5:0] op, funct;
  logic [1:0] basePc;
  logic wrEn, memWe, isBne, isJal;
  assign op = instruction[31:26];
  assign funct = instruction[5:0];
  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign rd = isJal ? 5'd31 : instruction[15:11];
  assign imm = instruction[15:0];
  assign jImm = {instruction[25:0], 2'b00};
  always_comb begin
    basePc = PC_PLUS4;
    regDst = 1'b0;
    wrEn = 1'b0;
    memWe = 1'b0;
    writebackSrc = WB_ALU;
    aluSrcB = 1'b0;
    extSel = 1'b1;
    aluCmd = ALU_ADD;
    isBne = 1'b0;
    isJal = 1'b0;
    case (op)
      OP_RTYPE:
        case (funct)
          F_ADD: wrEn = 1'b1;
          F_SUB: begin wrEn = 1'b1; aluCmd = ALU_SUB; end
          F_SLT: begin wrEn = 1'b1; aluCmd = ALU_SLT; end
          F_JR: basePc = PC_REG;
          default: ;
        endcase
      OP_ADDI: begin regDst = 1'b1; wrEn = 1'b1; aluSrcB = 1'b1; end
      OP_XORI: begin regDst = 1'b1; wrEn = 1'b1; aluSrcB = 1'b1; extSel = 1'b0; aluCmd = ALU_XOR; end
      OP_LW: begin regDst = 1'b1; wrEn = 1'b1; aluSrcB = 1'b1; writebackSrc = WB_MEM; end
      OP_SW: begin memWe = 1'b1; aluSrcB = 1'b1; end
      OP_BNE: begin aluCmd = ALU_SUB; isBne = 1'b1; end
      OP_J: basePc = PC_JUMP;
      OP_JAL: begin basePc = PC_JUMP; wrEn = 1'b1; writebackSrc = WB_PC4; isJal = 1'b1; end
      default: ;
    endcase
  end
  // Branch resolution sits outside the decode block so aluZero never feeds back into it
  assign pcSrc = !rst_n ? PC_PLUS4 : isBne ? (aluZero ? PC_PLUS4 : PC_BRANCH) : basePc;
  assign regWrEn = rst_n & wrEn;
  assign memWrEn = rst_n & memWe;
endmodule

// File: rtl/decode_alu_dmem_dmem.sv
// data_memory: word-addressed RAM, combinational read, sync write, async clear
module data_memory #(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wrData,
  input  logic          wrEn,
  output logic [31:0]   rdData
);
  logic [31:0] mem [MEM_WORDS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    else if (wrEn) mem[addr] <= wrData;
  assign rdData = rst_n ? mem[addr] : '0;
endmodule

// File: rtl/decode_alu_dmem.sv
// decode_alu_dmem: decode, extend/B-mux, ALU and data memory of the single-cycle CPU
module decode_alu_dmem
  import decode_alu_dmem_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [27:0] jImm,
  output logic [1:0]  pcSrc,
  output logic        regDst,
  output logic        regWrEn,
  output logic [1:0]  writebackSrc,
  output logic [31:0] aluOut,
  output logic        aluZero,
  output logic        carryout,
  output logic        overflow,
  output logic [31:0] dataMemOut
);
  localparam int AW = $clog2(MEM_WORDS);
  logic extSel, aluSrcB, memWrEn;
  aluCmd_t aluCmd;
  logic [31:0] immExt, operandB;
  instruction_decoder uDec (
    .rst_n, .instruction, .aluZero, .rs, .rt, .rd, .imm, .jImm, .pcSrc, .regDst,
    .regWrEn, .writebackSrc, .memWrEn, .aluSrcB, .extSel, .aluCmd
  );
  assign immExt = extSel ? {{16{imm[15]}}, imm} : {16'b0, imm};
  assign operandB = aluSrcB ? immExt : readData2;
  alu32 uAlu (
    .a(readData1), .b(operandB), .cmd(aluCmd), .result(aluOut), .zero(aluZero),
    .carryout, .overflow
  );
  data_memory #(.MEM_WORDS(MEM_WORDS)) uMem (
    .clk, .rst_n, .addr(aluOut[AW+1:2]), .wrData(readData2), .wrEn(memWrEn),
    .rdData(dataMemOut)
  );
endmodule

// File: tb/tb_decode_alu_dmem.sv
// tb_decode_alu_dmem: scoreboard bench with a behavioural CPU-slice model
module tb_decode_alu_dmem;
  import decode_alu_dmem_pkg::*;
  localparam int MW = 256;
  logic clk, rst_n;
  logic [31:0] instruction, readData1, readData2;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic [27:0] jImm;
  logic [1:0] pcSrc, writebackSrc;
  logic regDst, regWrEn, aluZero, carryout, overflow;
  logic [31:0] aluOut, dataMemOut;
  int checks = 0, errors = 0;
  logic [31:0] modelMem [MW];

  typedef struct {
    string name;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [27:0] jImm;
    logic [1:0] pcSrc, wbSrc;
    logic regDst, regWrEn, writes, useAlu, aluZero, carry, ovf;
    logic [31:0] aluOut, dmem;
  } exp_t;
  exp_t q[$];

  decode_alu_dmem #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .readData1(readData1),
    .readData2(readData2), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jImm(jImm),
    .pcSrc(pcSrc), .regDst(regDst), .regWrEn(regWrEn), .writebackSrc(writebackSrc),
    .aluOut(aluOut), .aluZero(aluZero), .carryout(carryout), .overflow(overflow),
    .dataMemOut(dataMemOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ins, a, r2, input logic rn, input string nm);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] b, r;
    longint sa, sb, s;
    int mode;
    op = ins[31:26];
    fn = ins[5:0];
    e.name = nm;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = (op == 6'h03) ? 5'd31 : ins[15:11];
    e.imm = ins[15:0];
    e.jImm = {ins[25:0], 2'b00};
    e.pcSrc = 0; e.wbSrc = 0; e.regDst = 0; e.writes = 0; e.useAlu = 0;
    mode = 0;
    b = r2;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      e.writes = 1; e.useAlu = 1; mode = (fn == 6'h22) ? 1 : (fn == 6'h2A) ? 2 : 0;
    end else if (op == 6'h00 && fn == 6'h08) e.pcSrc = 1;
    else if (op == 6'h08 || op == 6'h23) begin
      e.regDst = 1; e.writes = 1; e.useAlu = 1; b = $signed(ins[15:0]); e.wbSrc = (op == 6'h23) ? 1 : 0;
    end else if (op == 6'h0E) begin
      e.regDst = 1; e.writes = 1; e.useAlu = 1; b = {16'h0, ins[15:0]}; mode = 3;
    end else if (op == 6'h2B) begin
      e.useAlu = 1; b = $signed(ins[15:0]);
    end else if (op == 6'h05) begin
      e.useAlu = 1; mode = 1;
    end else if (op == 6'h02) e.pcSrc = 2;
    else if (op == 6'h03) begin
      e.pcSrc = 2; e.writes = 1; e.wbSrc = 2;
    end
    sa = $signed(a);
    sb = $signed(b);
    if (mode == 0) begin r = a + b; e.carry = r < a; s = sa + sb; end
    else if (mode == 3) begin r = a ^ b; e.carry = 0; s = 0; end
    else begin r = a - b; e.carry = a >= b; s = sa - sb; end
    if (mode == 2) r = (sa < sb) ? 32'd1 : 32'd0;
    e.ovf = (mode != 3) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    e.aluOut = r;
    e.aluZero = r == 0;
    if (op == 6'h05) e.pcSrc = (r != 0) ? 2'd3 : 2'd0;
    e.regWrEn = e.writes;
    if (!rn) begin e.pcSrc = 0; e.regWrEn = 0; end
    e.dmem = rn ? modelMem[(r >> 2) % MW] : 32'h0;
    return e;
  endfunction

  task automatic send(input logic [31:0] ins, a, r2, input logic rn, input string nm);
    @(posedge clk);
    #1;
    instruction = ins; readData1 = a; readData2 = r2; rst_n = rn;
    if (!rn) for (int i = 0; i < MW; i++) modelMem[i] = 32'h0;
    q.push_back(model(ins, a, r2, rn, nm));
    if (rn && ins[31:26] == 6'h2B) modelMem[((a + 32'($signed(ins[15:0]))) >> 2) % MW] = r2;
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "rs", 32'(rs), 32'(e.rs));
      chk(e.name, "rt", 32'(rt), 32'(e.rt));
      chk(e.name, "rd", 32'(rd), 32'(e.rd));
      chk(e.name, "imm", 32'(imm), 32'(e.imm));
      chk(e.name, "jImm", 32'(jImm), 32'(e.jImm));
      chk(e.name, "pcSrc", 32'(pcSrc), 32'(e.pcSrc));
      chk(e.name, "regWrEn", 32'(regWrEn), 32'(e.regWrEn));
      if (e.writes) begin
        chk(e.name, "regDst", 32'(regDst), 32'(e.regDst));
        chk(e.name, "writebackSrc", 32'(writebackSrc), 32'(e.wbSrc));
      end
      if (e.useAlu) begin
        chk(e.name, "aluOut", aluOut, e.aluOut);
        chk(e.name, "aluZero", 32'(aluZero), 32'(e.aluZero));
        chk(e.name, "carryout", 32'(carryout), 32'(e.carry));
        chk(e.name, "overflow", 32'(overflow), 32'(e.ovf));
        chk(e.name, "dataMemOut", dataMemOut, e.dmem);
      end else if (!rst_n) chk(e.name, "dataMemOut", dataMemOut, 32'h0);
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] v);
    return {op, 5'd4, 5'd5, v};
  endfunction

  initial begin
    logic [5:0] ops [11];
    ops = '{OP_RTYPE, OP_RTYPE, OP_ADDI, OP_XORI, OP_LW, OP_SW, OP_BNE, OP_J, OP_JAL, 6'h3F, 6'h01};
    instruction = 0; readData1 = 0; readData2 = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    send(rtype(F_ADD), 32'h1, 32'h2, 1'b0, "reset");
    send(rtype(F_ADD), 32'h7FFFFFFF, 32'h1, 1'b1, "addOvf");
    send(rtype(F_SUB), 32'd5, 32'd5, 1'b1, "subZero");
    send(rtype(F_SLT), 32'hFFFFFFFF, 32'h1, 1'b1, "sltNeg");
    send(itype(OP_XORI, 16'h8001), 32'h0000FFFF, 32'h0, 1'b1, "xoriZext");
    send(itype(OP_SW, 16'h4), 32'h10, 32'hDEADBEEF, 1'b1, "sw");
    send(itype(OP_LW, 16'h4), 32'h10, 32'h0, 1'b1, "lw");
    send(itype(OP_LW, 16'h4), 32'h410, 32'h0, 1'b1, "lwWrap");
    send(itype(OP_BNE, 16'h10), 32'd3, 32'd3, 1'b1, "bneEq");
    send(itype(OP_BNE, 16'h10), 32'd3, 32'd4, 1'b1, "bneNe");
    send({OP_JAL, 26'h40}, 32'h0, 32'h0, 1'b1, "jal");
    send(rtype(F_JR), 32'h1234, 32'h0, 1'b1, "jr");
    send(itype(OP_LW, 16'h4), 32'h10, 32'h0, 1'b0, "rstLw");
    send(itype(OP_SW, 16'h4), 32'h10, 32'h12345678, 1'b0, "rstSw");
    send(itype(OP_LW, 16'h4), 32'h10, 32'h0, 1'b1, "postRstLw");
    send(32'hFC00_0000 | 32'h0012_3456, 32'h5, 32'h6, 1'b1, "illegal");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins, a, b;
      int k;
      k = $urandom_range(0, 10);
      ins = $urandom;
      a = $urandom;
      b = $urandom;
      ins[31:26] = ops[k];
      if (k == 0) ins[5:0] = ($urandom_range(0, 1) == 1) ? F_ADD : F_SUB;
      if (k == 1) ins[5:0] = ($urandom_range(0, 1) == 1) ? F_SLT : (($urandom_range(0, 1) == 1) ? F_JR : 6'h00);
      if ($urandom_range(0, 3) == 0) b = a;
      if (k == 4 || k == 5) begin
        a = 32'($urandom_range(0, 31)) * 4 + (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h0);
        ins[15:0] = 16'($urandom_range(0, 15) * 4);
      end
      send(ins, a, b, $urandom_range(0, 40) != 0, "rand");
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("end", "pendingQueue", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
